// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between instruction fetch (IF) and data (D) requesters.
// Optional build macro MEM_ARB_TIMEOUT_EN adds a wait-state abort with err reporting.
//
// state  | meaning
// IDLE   | no access; grants one pending requester (D first, IF on starvation)
// ACCESS | mem_req held with the latched command until mem_ready (or timeout abort)
// RESP   | owner's rvalid pulse with the captured read data; no grants issued
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_WAIT     = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                err
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] STARVE_L = 4'(STARVE_LIMIT);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_LIMIT out of range 1..15");
    end
    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_wait
        $error("mem_port_arbiter: MAX_WAIT out of range 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              owner_d_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] rdata_q;
    logic [3:0]        starve_cnt;

    logic grant_if;
    logic grant_d;
    logic mem_done;
    logic mem_abort;
    logic timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

    // Down-counter of wait cycles still allowed; abort when it reaches zero without mem_ready.
    logic [7:0] wait_left;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_left <= '0;
        end else if (grant_if || grant_d) begin
            wait_left <= MAX_WAIT_L;
        end else if (state == S_ACCESS && wait_left != 8'd0) begin
            wait_left <= wait_left - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (mem_done) begin
            err_q <= 1'b0;
        end else if (mem_abort) begin
            err_q <= 1'b1;
        end
    end

    assign timeout_hit = (wait_left == 8'd0);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        mem_done  = 1'b0;
        mem_abort = 1'b0;
        case (state)
            S_IDLE: begin
                if (!reset) begin
                    if (if_req && (!d_req || starve_cnt == STARVE_L)) begin
                        grant_if = 1'b1;
                    end else if (d_req) begin
                        grant_d = 1'b1;
                    end
                end
                if (grant_if || grant_d) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    mem_done  = 1'b1;
                    state_nxt = S_RESP;
                end else if (timeout_hit) begin
                    mem_abort = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_d_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
        end else begin
            if (grant_if) begin
                owner_d_q <= 1'b0;
                we_q      <= 1'b0;
                addr_q    <= if_addr;
                wdata_q   <= '0;
                be_q      <= '1;
            end else if (grant_d) begin
                owner_d_q <= 1'b1;
                we_q      <= d_we;
                addr_q    <= d_addr;
                wdata_q   <= d_wdata;
                be_q      <= d_be;
            end
            if (mem_done) begin
                rdata_q <= we_q ? '0 : mem_rdata;
            end else if (mem_abort) begin
                rdata_q <= '0;
            end
        end
    end

    // Counts consecutive D grants that left a waiting IF behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!if_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_L) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else if (grant_if) begin
            starve_cnt <= '0;
        end
    end

    always_comb begin
        if_gnt    = grant_if;
        d_gnt     = grant_d;
        busy      = (state != S_IDLE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        err       = 1'b0;
        if (state == S_ACCESS) begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_be    = be_q;
        end
        if (state == S_RESP) begin
            if (owner_d_q) begin
                d_rvalid = 1'b1;
                d_rdata  = rdata_q;
            end else begin
                if_rvalid = 1'b1;
                if_rdata  = rdata_q;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            err = err_q;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus random traffic checked against a transaction model.
// Honours MEM_ARB_TIMEOUT_EN the same way as the design.
module tb_mem_port_arbiter;

    localparam int STARVE = 2;
    localparam int MAXW   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy, err;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE), .MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one command in flight at a time, then one reply slot.
    typedef struct {
        bit        is_d;
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [3:0]  be;
        bit [31:0] result;
        bit        aborted;
        int        waited;
    } txn_t;

    txn_t m_txn;
    bit   m_valid     = 0;
    bit   m_in_flight = 0;
    bit   m_reply_due = 0;
    int   m_streak    = 0;

    logic        seen_if_gnt, seen_d_gnt, seen_if_rvalid, seen_d_rvalid;
    logic        seen_mem_req, seen_mem_we, seen_busy, seen_err;
    logic [31:0] seen_if_rdata, seen_d_rdata, seen_mem_addr, seen_mem_wdata;
    logic [3:0]  seen_mem_be;

    task automatic compare_and_step();
        bit e_busy, e_if_gnt, e_d_gnt, e_if_own, e_d_own;
        seen_if_gnt = if_gnt;     seen_d_gnt = d_gnt;
        seen_if_rvalid = if_rvalid; seen_d_rvalid = d_rvalid;
        seen_if_rdata = if_rdata; seen_d_rdata = d_rdata;
        seen_mem_req = mem_req;   seen_mem_we = mem_we;
        seen_mem_addr = mem_addr; seen_mem_wdata = mem_wdata;
        seen_mem_be = mem_be;     seen_busy = busy; seen_err = err;

        e_busy   = m_in_flight || m_reply_due;
        e_if_gnt = 0;
        e_d_gnt  = 0;
        if (!e_busy && !reset && (if_req || d_req)) begin
            if (if_req && (!d_req || m_streak == STARVE)) e_if_gnt = 1;
            else e_d_gnt = 1;
        end
        e_if_own = m_reply_due && !m_txn.is_d;
        e_d_own  = m_reply_due && m_txn.is_d;

        if (m_valid) begin
            check("if_gnt", if_gnt, e_if_gnt);
            check("d_gnt", d_gnt, e_d_gnt);
            check("busy", busy, e_busy);
            check("mem_req", mem_req, m_in_flight);
            check("mem_we", mem_we, m_in_flight ? m_txn.we : 1'b0);
            check("mem_addr", mem_addr, m_in_flight ? m_txn.addr : 32'h0);
            check("mem_wdata", mem_wdata, m_in_flight ? m_txn.wdata : 32'h0);
            check("mem_be", mem_be, m_in_flight ? m_txn.be : 4'h0);
            check("if_rvalid", if_rvalid, e_if_own);
            check("d_rvalid", d_rvalid, e_d_own);
            check("if_rdata", if_rdata, e_if_own ? m_txn.result : 32'h0);
            check("d_rdata", d_rdata, e_d_own ? m_txn.result : 32'h0);
            check("err", err, m_reply_due && m_txn.aborted);
        end

        if (reset) begin
            m_valid     = 1;
            m_in_flight = 0;
            m_reply_due = 0;
            m_streak    = 0;
        end else if (m_valid) begin
            if (m_reply_due) begin
                m_reply_due = 0;
            end else if (m_in_flight) begin
                if (mem_ready) begin
                    m_txn.result  = m_txn.we ? 32'h0 : mem_rdata;
                    m_txn.aborted = 0;
                    m_in_flight   = 0;
                    m_reply_due   = 1;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (m_txn.waited == MAXW) begin
                    m_txn.result  = 32'h0;
                    m_txn.aborted = 1;
                    m_in_flight   = 0;
                    m_reply_due   = 1;
                end
`endif
                else begin
                    m_txn.waited++;
                end
            end else if (e_if_gnt) begin
                m_txn = '{is_d: 0, we: 0, addr: if_addr, wdata: 0, be: 4'hF,
                          result: 0, aborted: 0, waited: 0};
                m_in_flight = 1;
                m_streak    = 0;
            end else if (e_d_gnt) begin
                m_txn = '{is_d: 1, we: d_we, addr: d_addr, wdata: d_we ? d_wdata : d_wdata,
                          be: d_be, result: 0, aborted: 0, waited: 0};
                m_in_flight = 1;
                m_streak    = if_req ? ((m_streak < STARVE) ? m_streak + 1 : STARVE) : 0;
            end
        end
    endtask

    task automatic tick();
        #3;
        compare_and_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic t_if_read(input logic [31:0] addr, input logic [31:0] data);
        if_req = 1; if_addr = addr; mem_ready = 1; mem_rdata = data;
        tick();
        check("if_read_gnt", seen_if_gnt, 1);
        if_req = 0;
        tick();
        check("if_read_mem_req", seen_mem_req, 1);
        check("if_read_mem_addr", seen_mem_addr, addr);
        tick();
        check("if_read_rvalid", seen_if_rvalid, 1);
        check("if_read_rdata", seen_if_rdata, data);
        tick();
        check("if_read_idle", seen_busy, 0);
        mem_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] order;
        int         n;
        int         acc;

        reset = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_be = 0; mem_ready = 0; mem_rdata = 0;
        @(posedge clk); #1;
        tick(); tick();
        reset = 0;
        tick();
        check("rst_busy", seen_busy, 0);
        check("rst_mem_req", seen_mem_req, 0);
        check("rst_mem_addr", seen_mem_addr, 0);
        check("rst_if_rdata", seen_if_rdata, 0);
        check("rst_d_rdata", seen_d_rdata, 0);
        check("rst_err", seen_err, 0);

        // IF read with zero wait states
        t_if_read(32'h100, 32'h13);

        // contested grant: D first, IF after D's reply
        if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h200;
        mem_ready = 1; mem_rdata = 32'h1234;
        tick();
        check("contest_d_first", seen_d_gnt, 1);
        check("contest_if_held", seen_if_gnt, 0);
        check("contest_streak1", m_streak, 1);
        d_req = 0;
        tick(); tick();
        check("contest_d_rvalid", seen_d_rvalid, 1);
        check("contest_d_rdata", seen_d_rdata, 32'h1234);
        tick();
        check("contest_if_gnt", seen_if_gnt, 1);
        check("contest_streak0", m_streak, 0);
        if_req = 0;
        drain(3);

        // starvation guard with both requests held
        if_req = 1; d_req = 1; d_we = 0; mem_ready = 1;
        order = '0; n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            tick();
            if (seen_if_gnt || seen_d_gnt) begin
                order[n] = seen_if_gnt;
                n++;
            end
        end
        check("starve_grants", n, 6);
        check("starve_order", order, 6'b100100);
        if_req = 0; d_req = 0;
        drain(3);

        // store with three wait states
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
        mem_ready = 0; mem_rdata = 32'hFFFFFFFF;
        tick();
        check("store_gnt", seen_d_gnt, 1);
        d_req = 0; d_we = 0; d_wdata = 0; d_be = 0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1;
            tick();
            if (seen_mem_req && seen_mem_we && seen_mem_be == 4'h3 &&
                seen_mem_addr == 32'h40 && seen_mem_wdata == 32'hDEADBEEF) acc++;
        end
        check("store_stable_cycles", acc, 4);
        mem_ready = 0;
        tick();
        check("store_rvalid", seen_d_rvalid, 1);
        check("store_rdata", seen_d_rdata, 0);
        check("store_err", seen_err, 0);
        drain(2);

`ifdef MEM_ARB_TIMEOUT_EN
        // abort after MAX_WAIT+1 access cycles
        d_req = 1; d_we = 0; d_addr = 32'h80; mem_ready = 0; mem_rdata = 32'hAAAA5555;
        tick();
        d_req = 0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (seen_mem_req) acc++; end
        check("tmo_access_cycles", acc, 5);
        tick();
        check("tmo_rvalid", seen_d_rvalid, 1);
        check("tmo_err", seen_err, 1);
        check("tmo_rdata", seen_d_rdata, 0);
        drain(2);
        // mem_ready on the last allowed cycle beats the timeout
        d_req = 1; mem_ready = 0; mem_rdata = 32'h55AA;
        tick();
        d_req = 0;
        for (int i = 0; i < 4; i++) tick();
        mem_ready = 1;
        tick();
        mem_ready = 0;
        tick();
        check("tmo_race_rvalid", seen_d_rvalid, 1);
        check("tmo_race_err", seen_err, 0);
        check("tmo_race_rdata", seen_d_rdata, 32'h55AA);
        drain(2);
`else
        // without the timeout, ACCESS simply keeps waiting
        d_req = 1; d_we = 0; d_addr = 32'h80; mem_ready = 0; mem_rdata = 32'h55AA;
        tick();
        d_req = 0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (seen_mem_req && !seen_d_rvalid) acc++; end
        check("nowait_hold", acc, 12);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        tick();
        check("nowait_rvalid", seen_d_rvalid, 1);
        check("nowait_err", seen_err, 0);
        check("nowait_rdata", seen_d_rdata, 32'h55AA);
        drain(2);
`endif

        // reset during ACCESS discards the transaction
        if_req = 1; if_addr = 32'h500; mem_ready = 0;
        tick();
        if_req = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        tick();
        check("midrst_mem_req", seen_mem_req, 0);
        check("midrst_busy", seen_busy, 0);
        check("midrst_rvalid", seen_if_rvalid | seen_d_rvalid, 0);
        t_if_read(32'h100, 32'h13);

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if (if_req && seen_if_gnt) if_req = 0;
            if (d_req && seen_d_gnt) d_req = 0;
            if (!if_req && ($urandom % 3 == 0)) begin
                if_req = 1; if_addr = $urandom;
            end
            if (!d_req && ($urandom % 3 == 0)) begin
                d_req = 1; d_we = $urandom % 2; d_addr = $urandom;
                d_wdata = $urandom; d_be = 4'($urandom);
            end
            mem_ready = ($urandom % 3 == 0);
            mem_rdata = $urandom;
            reset = ($urandom % 150 == 0);
            tick();
        end
        reset = 0; if_req = 0; d_req = 0; mem_ready = 1;
        drain(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port of the multicycle RV32I core between two requesters: instruction fetch (IF) and data load/store (D). Each access is a registered, single-outstanding transaction with a req/gnt handshake toward the requesters and a req/ready handshake toward memory. The arbiter uses fixed data priority with a starvation guard for IF, and can optionally abort an access that exceeds a wait-state limit.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte enables are DATA_W/8 bits
STARVE_LIMIT, 4, consecutive contested D grants before IF is forced to win; legal range 1..15
MAX_WAIT, 15, wait cycles allowed in ACCESS before abort (timeout build only); legal range 1..255

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
if_req  in  1  IF read request; held until if_gnt
if_addr  in  ADDR_W  IF address
if_gnt  out  1  IF request accepted (combinational, 1-cycle pulse)
if_rvalid  out  1  IF response valid (1-cycle pulse)
if_rdata  out  DATA_W  IF read data, valid with if_rvalid
d_req  in  1  D request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  D address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  store byte enables
d_gnt  out  1  D request accepted (combinational, 1-cycle pulse)
d_rvalid  out  1  D response/completion (1-cycle pulse)
d_rdata  out  DATA_W  load data, valid with d_rvalid
mem_req  out  1  memory access active
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_ready  in  1  memory completes access this cycle
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
busy  out  1  state != IDLE
err  out  1  access aborted by timeout; pulses with rvalid

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, port name reset.
- Reset values: state=IDLE, starve_cnt=0, wait_cnt=0. All outputs are 0, including data and address outputs.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, grant exactly one requester (gnt high this same cycle).
  - Latch owner, we, addr, wdata, be. For an IF grant, latch we=0 and be=all-ones.
  - Next state ACCESS.
- Priority:
  - D wins by default.
  - IF wins if if_req && starve_cnt==STARVE_LIMIT.
- starve_cnt:
  - On a D grant with if_req high: increment (saturates at STARVE_LIMIT).
  - On an IF grant, or a D grant with if_req low: clear.
- ACCESS:
  - mem_req=1; mem_* driven from the latched registers, stable for the whole state.
  - On mem_ready: capture mem_rdata (forced to 0 for writes) and go to RESP.
  - Otherwise wait_cnt++.
- RESP:
  - Owner's rvalid=1 for one cycle, rdata = captured value; the non-owner's rdata holds 0.
  - Next state IDLE. No grant is issued in RESP.
- Latency: gnt at cycle N, mem_req at N+1. With zero wait states, rvalid at N+2 and the next grant is possible at N+3.
- Single outstanding transaction. A req arriving while busy waits until IDLE; that is not an error.
- mem_ready is ignored outside ACCESS.
- wait_cnt clears on entry to ACCESS.
- Reset mid-transaction: at the next clk edge, state=IDLE and mem_req=0. No rvalid is issued and the captured data is discarded.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - If in ACCESS with wait_cnt==MAX_WAIT and mem_ready low, abort: go to RESP with rdata=0 and err=1 alongside the owner's rvalid.
  - If mem_ready and the timeout coincide, mem_ready wins: normal completion, err=0.
- Undefined: ACCESS waits indefinitely, err is tied 0, and wait_cnt is not implemented.

Test Plan:
1. IF read: if_req, if_addr=0x100, mem_ready at first ACCESS cycle, mem_rdata=0x00000013 -> if_gnt at N, mem_req/mem_addr=0x100 at N+1, if_rvalid with if_rdata=0x13 at N+2, busy low at N+3.
2. Simultaneous if_req and d_req (load 0x200) in IDLE -> d_gnt first; IF granted in the IDLE following D's RESP; starve_cnt=1 then 0.
3. STARVE_LIMIT=2, d_req and if_req held continuously -> grant order D, D, IF, D, D, IF.
4. Store d_addr=0x40, d_wdata=0xDEADBEEF, d_be=0x3, mem_ready after 3 wait cycles -> mem_we=1, mem_be=0x3, data stable for 4 ACCESS cycles, d_rvalid with d_rdata=0, err=0.
5. Timeout build, MAX_WAIT=4, mem_ready never asserted -> abort after 5 ACCESS cycles, d_rvalid and err pulse together, rdata=0. Repeat with mem_ready on the 5th ACCESS cycle -> normal completion, err=0.
6. reset asserted during ACCESS -> next cycle state IDLE, mem_req=0, busy=0, no rvalid; fresh if_req then completes as in case 1.
